// File: rtl/uart_rx_fifo_if.sv
// UART rx FIFO controller bus: receiver side, FCR/LSR host side, interrupts.
// master drives the controller inputs; slave is the controller itself.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          rx_enable;
  logic          fifo_en;
  logic          rx_flush;
  logic [1:0]    trig_sel;
  logic [3:0]    data_bits;
  logic          parity_en;
  logic          stop_bits;
  logic          sample_tick;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_pe;
  logic          rx_fe;
  logic          rx_en_out;
  logic          rd_strobe;
  logic          lsr_rd;
  logic [7:0]    rd_data;
  logic          lsr_dr;
  logic          lsr_oe;
  logic          lsr_pe;
  logic          lsr_fe;
  logic          lsr_fifo_err;
  logic          rda_int;
  logic          cto_int;
  logic [CW-1:0] count;

  modport master (
    output rx_enable, fifo_en, rx_flush,
    output trig_sel, data_bits, parity_en,
    output stop_bits, sample_tick,
    output rx_valid, rx_data, rx_pe, rx_fe,
    output rd_strobe, lsr_rd,
    input  rx_en_out, rd_data, lsr_dr,
    input  lsr_oe, lsr_pe, lsr_fe,
    input  lsr_fifo_err, rda_int, cto_int,
    input  count
  );

  modport slave (
    input  rx_enable, fifo_en, rx_flush,
    input  trig_sel, data_bits, parity_en,
    input  stop_bits, sample_tick,
    input  rx_valid, rx_data, rx_pe, rx_fe,
    input  rd_strobe, lsr_rd,
    output rx_en_out, rd_data, lsr_dr,
    output lsr_oe, lsr_pe, lsr_fe,
    output lsr_fifo_err, rda_int, cto_int,
    output count
  );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// 16550-style rx FIFO with LSR rx bits, RDA and character-timeout interrupts.
// Define UART_RX_TIMEOUT_EN to build the character-timeout counter.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH    = 16,
  parameter int TO_CHARS = 4
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] cap;
  logic          oe;
  logic          en_q;
  logic          flush;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr;
  logic          ovr;
  logic          dr;
  logic [9:0]    head;
  logic          head_err;
  logic          new_err;
  logic [4:0]    lvl;

  // A mode change is treated exactly like an FCR flush
  assign flush    = bus.rx_flush | (bus.fifo_en != en_q);
  assign cap      = bus.fifo_en ? CW'(DEPTH) : CW'(1);
  assign full     = cnt >= cap;
  assign dr       = cnt != '0;
  assign push     = bus.rx_valid & ~flush;
  assign pop      = bus.rd_strobe & dr & ~flush;
  assign wr       = push & (~full | pop);
  assign ovr      = push & full & ~pop;
  assign head     = mem[rd_ptr];
  assign head_err = |head[9:8];
  assign new_err  = bus.rx_pe | bus.rx_fe;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      err_cnt <= '0;
      oe      <= 1'b0;
      en_q    <= bus.fifo_en;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      err_cnt <= '0;
      oe      <= 1'b0;
      en_q    <= bus.fifo_en;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt     <= cnt + CW'(wr) - CW'(pop);
      err_cnt <= err_cnt + CW'(wr & new_err)
                 - CW'(pop & head_err);
      if (ovr) oe <= 1'b1;
      else if (bus.lsr_rd) oe <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr)
      mem[wr_ptr] <= {bus.rx_fe, bus.rx_pe, bus.rx_data};
  end

  always_comb begin
    lvl = 5'd1;
    if (bus.fifo_en) begin
      unique case (bus.trig_sel)
        2'b00:   lvl = 5'd1;
        2'b01:   lvl = 5'd4;
        2'b10:   lvl = 5'd8;
        default: lvl = 5'd14;
      endcase
    end
  end

  assign bus.rx_en_out    = bus.rx_enable & ~bus.rx_flush;
  assign bus.count        = cnt;
  assign bus.rd_data      = dr ? head[7:0] : 8'h00;
  assign bus.lsr_dr       = dr;
  assign bus.lsr_oe       = oe;
  assign bus.lsr_pe       = dr & head[8];
  assign bus.lsr_fe       = dr & head[9];
  assign bus.lsr_fifo_err = bus.fifo_en & (err_cnt != '0);
  assign bus.rda_int      = int'(cnt) >= int'(lvl);

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(12 * 16 * TO_CHARS + 1);

  logic [3:0]    char_bits;
  logic [TW-1:0] to_limit;
  logic [TW-1:0] to_cnt;
  logic          to_clr;
  logic          cto;

  assign char_bits = 4'd1 + bus.data_bits
                     + {3'd0, bus.parity_en}
                     + (bus.stop_bits ? 4'd2 : 4'd1);
  assign to_limit  = TW'(char_bits) * TW'(16 * TO_CHARS);
  assign to_clr    = push | pop | flush | ~dr | ~bus.fifo_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      cto    <= 1'b0;
    end else begin
      if (to_clr)
        to_cnt <= '0;
      else if (bus.sample_tick && to_cnt != to_limit)
        to_cnt <= to_cnt + TW'(1);
      // Set on the tick that brings the counter to the limit
      if (push | pop | flush)
        cto <= 1'b0;
      else if (bus.fifo_en && dr && bus.sample_tick
               && to_cnt == to_limit - TW'(1))
        cto <= 1'b1;
    end
  end

  assign bus.cto_int = cto;
`else
  logic unused_to;
  assign unused_to   = ^{bus.data_bits, bus.parity_en,
                         bus.stop_bits, bus.sample_tick};
  assign bus.cto_int = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: vector table, directed corners,
// and random traffic against a queue-based reference model.
module tb_uart_rx_fifo_ctrl;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo_ctrl #(
    .DEPTH(DEPTH),
    .TO_CHARS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [9:0] mq[$];
  logic       m_oe;
  logic       m_prev_en;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       rd;
    logic [4:0] cnt;
    logic [7:0] rdd;
    logic       dr;
    logic       epe;
    logic       efe;
    logic       ferr;
    logic       rda;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic v, logic [7:0] d, logic pe, logic fe, logic rd,
    logic [4:0] cnt, logic [7:0] rdd, logic dr,
    logic epe, logic efe, logic ferr, logic rda);
    vec_t r;
    r.v = v; r.d = d; r.pe = pe; r.fe = fe; r.rd = rd;
    r.cnt = cnt; r.rdd = rdd; r.dr = dr;
    r.epe = epe; r.efe = efe; r.ferr = ferr; r.rda = rda;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.rx_pe       = 1'b0;
    bus.rx_fe       = 1'b0;
    bus.rd_strobe   = 1'b0;
    bus.lsr_rd      = 1'b0;
    bus.rx_flush    = 1'b0;
    bus.sample_tick = 1'b0;
  endtask

  task automatic model_upd();
    bit fl;
    bit pp;
    int cap;
    fl = bus.rx_flush || (bus.fifo_en != m_prev_en);
    m_prev_en = bus.fifo_en;
    if (fl) begin
      mq.delete();
      m_oe = 1'b0;
    end else begin
      cap = bus.fifo_en ? DEPTH : 1;
      pp  = bus.rd_strobe && mq.size() > 0;
      if (bus.rx_valid && mq.size() >= cap && !pp) m_oe = 1'b1;
      else if (bus.lsr_rd) m_oe = 1'b0;
      if (pp) void'(mq.pop_front());
      if (bus.rx_valid && mq.size() < cap)
        mq.push_back({bus.rx_fe, bus.rx_pe, bus.rx_data});
    end
  endtask

  task automatic cyc();
    model_upd();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    int lvl;
    bit anyerr;
    logic [9:0] h;
    n = mq.size();
    h = (n > 0) ? mq[0] : 10'h0;
    anyerr = 1'b0;
    foreach (mq[i]) if (|mq[i][9:8]) anyerr = 1'b1;
    lvl = 1;
    if (bus.fifo_en)
      case (bus.trig_sel)
        2'b00: lvl = 1;
        2'b01: lvl = 4;
        2'b10: lvl = 8;
        default: lvl = 14;
      endcase
    chk({tag, ".count"}, 32'(bus.count), 32'(n));
    chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(h[7:0]));
    chk({tag, ".lsr_dr"}, 32'(bus.lsr_dr), 32'(n > 0));
    chk({tag, ".lsr_oe"}, 32'(bus.lsr_oe), 32'(m_oe));
    chk({tag, ".lsr_pe"}, 32'(bus.lsr_pe), 32'(h[8]));
    chk({tag, ".lsr_fe"}, 32'(bus.lsr_fe), 32'(h[9]));
    chk({tag, ".fifo_err"}, 32'(bus.lsr_fifo_err),
        32'(bus.fifo_en && anyerr));
    chk({tag, ".rda"}, 32'(bus.rda_int), 32'(n >= lvl));
`ifndef UART_RX_TIMEOUT_EN
    chk({tag, ".cto"}, 32'(bus.cto_int), 32'h0);
`endif
  endtask

  task automatic push(input logic [7:0] d);
    idle();
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    cyc();
  endtask

  task automatic read1();
    idle();
    bus.rd_strobe = 1'b1;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.rx_enable = 1'b1;
    bus.fifo_en   = 1'b1;
    bus.trig_sel  = 2'b01;
    bus.data_bits = 4'd8;
    bus.parity_en = 1'b0;
    bus.stop_bits = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_oe = 1'b0;
    m_prev_en = bus.fifo_en;

    chk("reset.count", 32'(bus.count), 32'h0);
    chk("reset.dr", 32'(bus.lsr_dr), 32'h0);
    chk("reset.oe", 32'(bus.lsr_oe), 32'h0);
    chk("reset.rd_data", 32'(bus.rd_data), 32'h0);
    chk("reset.rda", 32'(bus.rda_int), 32'h0);
    chk("reset.cto", 32'(bus.cto_int), 32'h0);
    chk("reset.ferr", 32'(bus.lsr_fifo_err), 32'h0);
    chk("reset.rx_en_out", 32'(bus.rx_en_out), 32'h1);

    //       v  d      pe fe rd  cnt rdd    dr pe fe er rda
    vt.push_back(mk(1, 8'h11, 0, 0, 0, 1, 8'h11, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 8'h22, 0, 0, 0, 2, 8'h11, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 8'h33, 0, 0, 0, 3, 8'h11, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 8'h44, 0, 0, 0, 4, 8'h11, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 3, 8'h22, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 2, 8'h33, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h44, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 8'h55, 1, 0, 0, 1, 8'h55, 1, 1, 0, 1, 0));
    vt.push_back(mk(1, 8'h66, 0, 0, 0, 2, 8'h55, 1, 1, 0, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h66, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 8'h77, 0, 1, 0, 2, 8'h66, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h77, 1, 0, 1, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      idle();
      bus.rx_valid  = vt[i].v;
      bus.rx_data   = vt[i].d;
      bus.rx_pe     = vt[i].pe;
      bus.rx_fe     = vt[i].fe;
      bus.rd_strobe = vt[i].rd;
      cyc();
      chk({t, ".count"}, 32'(bus.count), 32'(vt[i].cnt));
      chk({t, ".rd_data"}, 32'(bus.rd_data), 32'(vt[i].rdd));
      chk({t, ".dr"}, 32'(bus.lsr_dr), 32'(vt[i].dr));
      chk({t, ".pe"}, 32'(bus.lsr_pe), 32'(vt[i].epe));
      chk({t, ".fe"}, 32'(bus.lsr_fe), 32'(vt[i].efe));
      chk({t, ".ferr"}, 32'(bus.lsr_fifo_err), 32'(vt[i].ferr));
      chk({t, ".rda"}, 32'(bus.rda_int), 32'(vt[i].rda));
    end

    // overflow: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) push(8'hA0 + 8'(i));
    chk("ovf.count", 32'(bus.count), 32'd16);
    chk("ovf.oe", 32'(bus.lsr_oe), 32'h1);
    chk("ovf.head", 32'(bus.rd_data), 32'hA0);
    idle();
    bus.lsr_rd = 1'b1;
    cyc();
    chk("ovf.oe_clr", 32'(bus.lsr_oe), 32'h0);
    idle();
    bus.rx_valid  = 1'b1;
    bus.rx_data   = 8'hC0;
    bus.rd_strobe = 1'b1;
    cyc();
    chk("fullpp.count", 32'(bus.count), 32'd16);
    chk("fullpp.oe", 32'(bus.lsr_oe), 32'h0);
    chk("fullpp.head", 32'(bus.rd_data), 32'hA1);
    idle();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hC1;
    bus.lsr_rd   = 1'b1;
    cyc();
    chk("oe_vs_lsr_rd.oe", 32'(bus.lsr_oe), 32'h1);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("drain%0d", i), 32'(bus.rd_data),
          32'(8'hA1 + 8'(i)));
      read1();
    end
    chk("drain.count", 32'(bus.count), 32'd5);
    chk("drain.head", 32'(bus.rd_data), 32'hAC);
    chk("drain.oe", 32'(bus.lsr_oe), 32'h1);

    // flush with a coincident push
    idle();
    bus.rx_flush = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hEE;
    #1;
    chk("flush.rx_en_out", 32'(bus.rx_en_out), 32'h0);
    cyc();
    chk("flush.count", 32'(bus.count), 32'h0);
    chk("flush.oe", 32'(bus.lsr_oe), 32'h0);
    idle();
    #1;
    chk("flush.rx_en_back", 32'(bus.rx_en_out), 32'h1);

    // 16450 mode: one-entry holding register
    idle();
    bus.fifo_en = 1'b0;
    cyc();
    push(8'h12);
    push(8'h34);
    chk("m16450.count", 32'(bus.count), 32'h1);
    chk("m16450.oe", 32'(bus.lsr_oe), 32'h1);
    chk("m16450.head", 32'(bus.rd_data), 32'h12);
    chk("m16450.rda", 32'(bus.rda_int), 32'h1);
    bus.fifo_en = 1'b1;
    idle();
    cyc();
    chk("mode_flush.count", 32'(bus.count), 32'h0);
    chk("mode_flush.oe", 32'(bus.lsr_oe), 32'h0);

    // character timeout, 8N1 -> 640 ticks
    push(8'h5A);
    idle();
    bus.sample_tick = 1'b1;
    repeat (639) cyc();
`ifdef UART_RX_TIMEOUT_EN
    chk("cto.before", 32'(bus.cto_int), 32'h0);
    cyc();
    chk("cto.at_limit", 32'(bus.cto_int), 32'h1);
`else
    repeat (100) cyc();
    chk("cto.disabled", 32'(bus.cto_int), 32'h0);
`endif
    read1();
    chk("cto.read_clr", 32'(bus.cto_int), 32'h0);
    idle();
    bus.sample_tick = 1'b1;
    repeat (700) cyc();
    chk("cto.empty", 32'(bus.cto_int), 32'h0);
    check_model("post_dir");

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      int rdp;
      idle();
      rdp = ((c / 200) % 2 == 0) ? 25 : 70;
      if (c % 250 == 0) bus.trig_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) bus.fifo_en = ~bus.fifo_en;
      bus.rx_enable = 1'($urandom);
      bus.rx_flush  = ($urandom_range(0, 99) == 0);
      bus.rx_valid  = 1'($urandom);
      bus.rx_data   = 8'($urandom);
      bus.rx_pe     = ($urandom_range(0, 7) == 0);
      bus.rx_fe     = ($urandom_range(0, 7) == 0);
      bus.rd_strobe = ($urandom_range(0, 99) < rdp);
      bus.lsr_rd    = ($urandom_range(0, 9) == 0);
      #1;
      chk("rnd.rx_en_out", 32'(bus.rx_en_out),
          32'(bus.rx_enable & ~bus.rx_flush));
      cyc();
      check_model($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
